pfpu_wbtrack: RTL and testbench

Writeback tracker sitting directly downstream of the PFPU ALU. It records the destination register of every result-producing opcode at issue time, then pairs each ALU result (`r`/`r_valid`) with that destination after the opcode's fixed latency. It generates the register-file write port and flags any schedule violation. The PFPU is statically scheduled, so the block never stalls; it only tracks, writes back and reports errors.

---
 rtl/pfpu_wbtrack_pkg.sv | 46 ++++
 rtl/pfpu_wbtrack_if.sv | 25 ++
 rtl/pfpu_wbtrack_slots.sv | 53 +++++
 rtl/pfpu_wbtrack.sv | 78 +++++++
 tb/tb_pfpu_wbtrack.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pfpu_wbtrack_pkg.sv
// Shared PFPU definitions: opcode encodings, per-opcode result latency and the
// writeback slot record used by the tracker.
package pfpu_pkg;

  localparam int PFPU_DST_W = 7;

  localparam logic [3:0] PFPU_OP_NOP     = 4'h0;
  localparam logic [3:0] PFPU_OP_FADD    = 4'h1;
  localparam logic [3:0] PFPU_OP_FSUB    = 4'h2;
  localparam logic [3:0] PFPU_OP_FMUL    = 4'h3;
  localparam logic [3:0] PFPU_OP_FABS    = 4'h4;
  localparam logic [3:0] PFPU_OP_F2I     = 4'h5;
  localparam logic [3:0] PFPU_OP_I2F     = 4'h6;
  localparam logic [3:0] PFPU_OP_VECTOUT = 4'h7;
  localparam logic [3:0] PFPU_OP_SIN     = 4'h8;
  localparam logic [3:0] PFPU_OP_COS     = 4'h9;
  localparam logic [3:0] PFPU_OP_ABOVE   = 4'ha;
  localparam logic [3:0] PFPU_OP_EQUAL   = 4'hb;
  localparam logic [3:0] PFPU_OP_COPY    = 4'hc;
  localparam logic [3:0] PFPU_OP_IF      = 4'hd;
  localparam logic [3:0] PFPU_OP_TSIGN   = 4'he;
  localparam logic [3:0] PFPU_OP_QUAKE   = 4'hf;

  typedef struct packed {
    logic                  v;
    logic [PFPU_DST_W-1:0] dst;
  } slot_t;

  // Zero means the opcode produces no result and is not tracked.
  function automatic logic [3:0] pfpu_latency(input logic [3:0] op);
    logic [3:0] lat;
    case (op)
      PFPU_OP_FADD, PFPU_OP_FSUB: lat = 4'd5;
      PFPU_OP_FMUL:               lat = 4'd6;
      PFPU_OP_FABS:               lat = 4'd2;
      PFPU_OP_F2I:                lat = 4'd3;
      PFPU_OP_I2F:                lat = 4'd4;
      PFPU_OP_SIN, PFPU_OP_COS:   lat = 4'd5;
      PFPU_OP_ABOVE, PFPU_OP_EQUAL, PFPU_OP_COPY,
      PFPU_OP_IF, PFPU_OP_TSIGN, PFPU_OP_QUAKE: lat = 4'd2;
      default:                    lat = 4'd0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/pfpu_wbtrack_if.sv
// Issue/result/writeback bundle between the PFPU sequencer and the writeback tracker.
interface pfpu_wbtrack_if #(parameter int DST_W = pfpu_pkg::PFPU_DST_W);
  logic             flush;
  logic [3:0]       issue_opcode;
  logic [DST_W-1:0] issue_dst;
  logic [31:0]      r;
  logic             r_valid;
  logic             regf_we;
  logic [DST_W-1:0] regf_waddr;
  logic [31:0]      regf_wdat;
  logic             busy;
  logic             err_sched;
  logic             err_orphan;
  logic             err_missing;

  modport master (
    output flush, issue_opcode, issue_dst, r, r_valid,
    input  regf_we, regf_waddr, regf_wdat, busy, err_sched, err_orphan, err_missing
  );

  modport slave (
    input  flush, issue_opcode, issue_dst, r, r_valid,
    output regf_we, regf_waddr, regf_wdat, busy, err_sched, err_orphan, err_missing
  );
endinterface

// File: rtl/pfpu_wbtrack_slots.sv
// Delay-line of pending destinations: slot[k] is the result due k cycles ahead.
// Shifts toward slot 0 every cycle and inserts new issues at slot[L-1].
module pfpu_wbtrack_slots
  import pfpu_pkg::*;
#(
  parameter int MAXLAT = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  flush,
  input  logic                  ins_valid,
  input  logic [3:0]            ins_lat,
  input  logic [PFPU_DST_W-1:0] ins_dst,
  output slot_t                 head,
  output logic                  occupied,
  output logic                  collide
);

  slot_t slot_q [MAXLAT];
  slot_t slot_d [MAXLAT];

  always_comb begin
    for (int k = 0; k < MAXLAT - 1; k++) slot_d[k] = slot_q[k+1];
    slot_d[MAXLAT-1] = '0;
    collide = 1'b0;
    // An occupied slot[L] lands on slot[L-1] this edge, so the older entry wins.
    for (int k = 0; k < MAXLAT - 1; k++) begin
      if (ins_valid && (int'(ins_lat) == k + 1)) begin
        if (slot_q[k+1].v) collide = 1'b1;
        else               slot_d[k] = '{v: 1'b1, dst: ins_dst};
      end
    end
    if (flush) begin
      for (int k = 0; k < MAXLAT; k++) slot_d[k] = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < MAXLAT; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAXLAT; k++) slot_q[k] <= slot_d[k];
    end
  end

  always_comb begin
    occupied = 1'b0;
    for (int k = 0; k < MAXLAT; k++) occupied = occupied | slot_q[k].v;
  end

  assign head = slot_q[0];

endmodule

// File: rtl/pfpu_wbtrack.sv
// PFPU writeback tracker: pairs each ALU result with the destination recorded at
// issue time, drives the register-file write port and latches schedule errors.
module pfpu_wbtrack
  import pfpu_pkg::*;
#(
  parameter int DST_W  = PFPU_DST_W,
  parameter int MAXLAT = 8
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  pfpu_wbtrack_if.slave  bus
);

  logic [3:0]       issue_lat;
  logic             ins_valid;
  slot_t            head;
  logic             occupied;
  logic             collide;
  logic             match;

  logic             we_q;
  logic [DST_W-1:0] waddr_q;
  logic [31:0]      wdat_q;
  logic             sched_q;
  logic             orphan_q;
  logic             missing_q;

  assign issue_lat = pfpu_latency(bus.issue_opcode);
  assign ins_valid = (issue_lat != 4'd0);
  assign match     = head.v & bus.r_valid;

  pfpu_wbtrack_slots #(.MAXLAT(MAXLAT)) u_slots (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flush     (bus.flush),
    .ins_valid (ins_valid),
    .ins_lat   (issue_lat),
    .ins_dst   (bus.issue_dst),
    .head      (head),
    .occupied  (occupied),
    .collide   (collide)
  );

  // Match uses slot[0] before this edge's shift, so it is independent of any issue.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdat_q    <= '0;
      sched_q   <= 1'b0;
      orphan_q  <= 1'b0;
      missing_q <= 1'b0;
    end else if (bus.flush) begin
      we_q      <= 1'b0;
      sched_q   <= 1'b0;
      orphan_q  <= 1'b0;
      missing_q <= 1'b0;
    end else begin
      we_q <= match;
      if (match) begin
        waddr_q <= head.dst;
        wdat_q  <= bus.r;
      end
      if (collide)                   sched_q   <= 1'b1;
      if (bus.r_valid && !head.v)    orphan_q  <= 1'b1;
      if (head.v && !bus.r_valid)    missing_q <= 1'b1;
    end
  end

  assign bus.regf_we     = we_q;
  assign bus.regf_waddr  = waddr_q;
  assign bus.regf_wdat   = wdat_q;
  assign bus.busy        = occupied | we_q;
  assign bus.err_sched   = sched_q;
  assign bus.err_orphan  = orphan_q;
  assign bus.err_missing = missing_q;

endmodule

// File: tb/tb_pfpu_wbtrack.sv
// Bench for pfpu_wbtrack: directed scenarios plus random traffic, checked against
// a due-time map of outstanding results.
module tb_pfpu_wbtrack;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  pfpu_wbtrack_if #(.DST_W(7)) bus ();

  pfpu_wbtrack #(.DST_W(7), .MAXLAT(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Result latency per opcode value 0..15 (0 = no result).
  int lat_tab [16] = '{0, 5, 5, 6, 2, 3, 4, 0, 5, 5, 2, 2, 2, 2, 2, 2};

  // Model: absolute cycle at which a result is due -> its destination.
  int        exp_due [int];
  logic      m_we, m_sched, m_orph, m_miss;
  logic [6:0]  m_waddr;
  logic [31:0] m_wdat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_due.delete();
    m_we = 0; m_sched = 0; m_orph = 0; m_miss = 0;
    m_waddr = '0; m_wdat = '0;
  endtask

  task automatic drive_idle();
    bus.flush = 0; bus.issue_opcode = 4'h0; bus.issue_dst = '0;
    bus.r = '0; bus.r_valid = 0;
  endtask

  task automatic check_all();
    check("regf_we",     {31'd0, bus.regf_we},     {31'd0, m_we});
    check("regf_waddr",  {25'd0, bus.regf_waddr},  {25'd0, m_waddr});
    check("regf_wdat",   bus.regf_wdat,            m_wdat);
    check("busy",        {31'd0, bus.busy},        {31'd0, (m_we || exp_due.size() != 0)});
    check("err_sched",   {31'd0, bus.err_sched},   {31'd0, m_sched});
    check("err_orphan",  {31'd0, bus.err_orphan},  {31'd0, m_orph});
    check("err_missing", {31'd0, bus.err_missing}, {31'd0, m_miss});
  endtask

  // One clock cycle: drive at negedge, advance model, check just after posedge.
  task automatic step(input logic fl, input logic [3:0] op, input logic [6:0] dst,
                      input logic [31:0] rd, input logic rv);
    int  l;
    logic hit;
    @(negedge sys_clk);
    bus.flush = fl; bus.issue_opcode = op; bus.issue_dst = dst;
    bus.r = rd; bus.r_valid = rv;
    if (fl) begin
      exp_due.delete();
      m_we = 0; m_sched = 0; m_orph = 0; m_miss = 0;
    end else begin
      hit  = exp_due.exists(cyc);
      m_we = hit && rv;
      if (m_we) begin
        m_waddr = exp_due[cyc][6:0];
        m_wdat  = rd;
      end
      if (rv && !hit) m_orph = 1;
      if (hit && !rv) m_miss = 1;
      if (hit) exp_due.delete(cyc);
      l = lat_tab[op];
      if (l != 0) begin
        if (exp_due.exists(cyc + l)) m_sched = 1;
        else exp_due[cyc + l] = int'(dst);
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 7'h0, 32'h0, 0);
  endtask

  task automatic reset_mid();
    #2;
    drive_idle();
    sys_rst_n = 0;
    #1;
    model_clear();
    check("rst_we",   {31'd0, bus.regf_we},  32'd0);
    check("rst_busy", {31'd0, bus.busy},     32'd0);
    check_all();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  initial begin
    logic       fl, rv;
    logic [3:0] op;
    drive_idle();
    model_clear();
    repeat (3) @(negedge sys_clk);
    check_all();
    sys_rst_n = 1;

    // FMUL -> dst 0x12, result six cycles later, write one cycle after that.
    step(0, 4'h3, 7'h12, 32'h0, 0);
    idle(5);
    step(0, 4'h0, 7'h0, 32'h3F800000, 1);
    check("fmul_we",    {31'd0, bus.regf_we}, 32'd1);
    check("fmul_addr",  {25'd0, bus.regf_waddr}, 32'h12);
    check("fmul_data",  bus.regf_wdat, 32'h3F800000);
    check("fmul_noerr", {29'd0, bus.err_sched, bus.err_orphan, bus.err_missing}, 32'd0);
    idle(1);
    check("fmul_pulse", {31'd0, bus.regf_we}, 32'd0);

    // Out-of-order completion: COPY/FADD/F2I.
    step(1, 4'h0, 7'h0, 32'h0, 0);
    step(0, 4'hc, 7'd5, 32'h0, 0);
    step(0, 4'h1, 7'd6, 32'h0, 0);
    step(0, 4'h5, 7'd7, 32'hAAAA0005, 1);
    check("ooo_addr5", {25'd0, bus.regf_waddr}, 32'd5);
    idle(2);
    step(0, 4'h0, 7'h0, 32'hAAAA0007, 1);
    check("ooo_addr7", {25'd0, bus.regf_waddr}, 32'd7);
    step(0, 4'h0, 7'h0, 32'hAAAA0006, 1);
    check("ooo_addr6", {25'd0, bus.regf_waddr}, 32'd6);
    check("ooo_data6", bus.regf_wdat, 32'hAAAA0006);

    // Collision: COPY lands on the FMUL's cycle and is dropped.
    step(1, 4'h0, 7'h0, 32'h0, 0);
    step(0, 4'h3, 7'd1, 32'h0, 0);
    idle(3);
    step(0, 4'hc, 7'd2, 32'h0, 0);
    check("coll_sched", {31'd0, bus.err_sched}, 32'd1);
    idle(1);
    step(0, 4'h0, 7'h0, 32'h12345678, 1);
    check("coll_addr", {25'd0, bus.regf_waddr}, 32'd1);
    idle(2);
    check("coll_nomiss", {31'd0, bus.err_missing}, 32'd0);

    // Orphan result, then a withheld FADD result.
    step(1, 4'h0, 7'h0, 32'h0, 0);
    idle(3);
    step(0, 4'h0, 7'h0, 32'hDEAD, 1);
    check("orphan", {31'd0, bus.err_orphan}, 32'd1);
    check("orphan_nowe", {31'd0, bus.regf_we}, 32'd0);
    step(1, 4'h0, 7'h0, 32'h0, 0);
    step(0, 4'h1, 7'd9, 32'h0, 0);
    idle(4);
    check("miss_early", {31'd0, bus.err_missing}, 32'd0);
    idle(1);
    check("missing", {31'd0, bus.err_missing}, 32'd1);

    // Flush drops an outstanding FADD; its late result becomes an orphan.
    step(1, 4'h0, 7'h0, 32'h0, 0);
    step(0, 4'h1, 7'd3, 32'h0, 0);
    idle(1);
    step(1, 4'h0, 7'h0, 32'h0, 0);
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    idle(2);
    step(0, 4'h0, 7'h0, 32'h5, 1);
    check("flush_orphan", {31'd0, bus.err_orphan}, 32'd1);

    // Reset mid-stream.
    step(0, 4'h3, 7'd4, 32'h0, 0);
    idle(2);
    reset_mid();

    // Untracked opcodes never occupy a slot.
    for (int i = 0; i < 20; i++) begin
      step(0, ($urandom_range(0, 1) != 0) ? 4'h7 : 4'h0, 7'($urandom_range(0, 127)), 32'h0, 0);
      check("untracked_busy", {31'd0, bus.busy}, 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) reset_mid();
      fl = ($urandom_range(0, 29) == 0);
      op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      rv = exp_due.exists(cyc) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
      step(fl, op, 7'($urandom_range(0, 127)), $urandom, rv);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
